// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between fetch and the memory controller.
// Hits answer one cycle after the request. A miss issues a single word fetch, fills the line and forwards the word.
module icache #(
   parameter int INDEX_BITS = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_hit_o,
   output logic [31:0] if_inst_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_done_i,
   input  logic [31:0] mem_data_i
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   typedef enum logic {
      IDLE      = 1'b0,
      MISS_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [31:0]           r_data [LINES];

   logic [INDEX_BITS-1:0] w_idx;
   logic [INDEX_BITS-1:0] w_fill_idx;
   logic [TAG_W-1:0]      w_tag;
   logic [TAG_W-1:0]      w_fill_tag;
   logic                  w_lookup_hit;
   logic                  w_hit_nxt;
   logic                  w_fill;
   logic [31:0]           w_inst_nxt;
   logic [31:0]           w_addr_nxt;
   logic                  w_unused;

   assign w_idx        = if_addr_i[INDEX_BITS+1:2];
   assign w_tag        = if_addr_i[31:INDEX_BITS+2];
   assign w_fill_idx   = mem_addr_o[INDEX_BITS+1:2];
   assign w_fill_tag   = mem_addr_o[31:INDEX_BITS+2];
   assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_unused     = ^if_addr_i[1:0];

   // Request drops in the done cycle so the controller does not re-issue.
   assign mem_req_o = (r_state == MISS_WAIT) && !mem_done_i;

   always_comb begin
      w_state_nxt = r_state;
      w_hit_nxt   = 1'b0;
      w_fill      = 1'b0;
      w_inst_nxt  = if_inst_o;
      w_addr_nxt  = mem_addr_o;
      if (clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (!if_hit_o && if_req_i) begin
                  if (w_lookup_hit) begin
                     w_hit_nxt  = 1'b1;
                     w_inst_nxt = r_data[w_idx];
                  end else begin
                     w_addr_nxt  = {if_addr_i[31:2], 2'b00};
                     w_state_nxt = MISS_WAIT;
                  end
               end
            end
            MISS_WAIT: begin
               if (mem_done_i) begin
                  w_fill      = 1'b1;
                  w_hit_nxt   = 1'b1;
                  w_inst_nxt  = mem_data_i;
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state    <= IDLE;
         if_hit_o   <= 1'b0;
         if_inst_o  <= 32'h0;
         mem_addr_o <= 32'h0;
      end else if (rdy_in) begin
         r_state    <= w_state_nxt;
         if_hit_o   <= w_hit_nxt;
         if_inst_o  <= w_inst_nxt;
         mem_addr_o <= w_addr_nxt;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_valid <= '0;
      end else if (rdy_in && w_fill) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // Data and tag arrays carry no reset; valid bits alone gate their use.
   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && w_fill) begin
         r_data[w_fill_idx] <= mem_data_i;
         r_tag[w_fill_idx]  <= w_fill_tag;
      end
   end

endmodule
